// File: rtl/alu_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
package alu_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned OP_W  = 4;

  localparam logic [OP_W-1:0] ALU_OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] ALU_OP_SUB = 4'b0010;
  localparam logic [OP_W-1:0] ALU_OP_AND = 4'b0011;
  localparam logic [OP_W-1:0] ALU_OP_OR  = 4'b0100;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } sched_state_t;

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between two requesters and the shared ALU scheduler.
// Grant counters and stats_clr exist only with ALU_RR_SCHEDULER_STATS_EN.
interface alu_rr_scheduler_if
  import alu_pkg::*;
();

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [OP_W-1:0]  req_op0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic [OP_W-1:0]  req_op1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_err;
  logic             busy;
`ifdef ALU_RR_SCHEDULER_STATS_EN
  logic             stats_clr;
  logic [15:0]      grant_cnt0;
  logic [15:0]      grant_cnt1;
`endif

  modport master (
    output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err, busy
`ifdef ALU_RR_SCHEDULER_STATS_EN
    , output stats_clr
    , input  grant_cnt0, grant_cnt1
`endif
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err, busy
`ifdef ALU_RR_SCHEDULER_STATS_EN
    , input  stats_clr
    , output grant_cnt0, grant_cnt1
`endif
  );

endinterface

// File: rtl/alu.sv
// Combinational 16-bit ALU: add/sub/and/or; unknown op codes give zero and err.
module alu
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] result_c_o,
  output logic             err_c_o
);

  always_comb begin
    result_c_o = '0;
    err_c_o    = 1'b0;
    case (op_i)
      ALU_OP_ADD: result_c_o = a_i + b_i;
      ALU_OP_SUB: result_c_o = a_i - b_i;
      ALU_OP_AND: result_c_o = a_i & b_i;
      ALU_OP_OR:  result_c_o = a_i | b_i;
      default:    err_c_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; on contention the requester that did not win last time wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_c_o
);

  always_comb begin
    gnt_c_o = 2'b00;
    case (req_i)
      2'b01:   gnt_c_o = 2'b01;
      2'b10:   gnt_c_o = 2'b10;
      2'b11:   gnt_c_o = last_grant_i ? 2'b01 : 2'b10;
      default: gnt_c_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU between two requesters: round-robin accept, one-cycle execute, held response.
// Optional per-requester grant counters under ALU_RR_SCHEDULER_STATS_EN.
module alu_rr_scheduler
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_rr_scheduler_if.slave bus
);

  sched_state_t     state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic [1:0]       gnt_c;
  logic [1:0]       req_ready_c;
  logic             accept_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_err_c;

  rr_arb2 u_arb (
    .req_i        (bus.req_valid),
    .last_grant_i (last_grant_q),
    .gnt_c_o      (gnt_c)
  );

  alu u_alu (
    .a_i        (a_q),
    .b_i        (b_q),
    .op_i       (op_q),
    .result_c_o (alu_res_c),
    .err_c_o    (alu_err_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      rsp_valid_q  <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      result_q     <= result_d;
      err_q        <= err_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  // gnt_c is only ever set for a valid requester, so a grant in IDLE is an acceptance
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    result_d     = result_q;
    err_d        = err_q;
    rsp_valid_d  = rsp_valid_q;
    req_ready_c  = 2'b00;
    accept_c     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_c = gnt_c;
        if (gnt_c != 2'b00) begin
          accept_c     = 1'b1;
          owner_d      = gnt_c[1];
          last_grant_d = gnt_c[1];
          a_d          = gnt_c[1] ? bus.req_a1  : bus.req_a0;
          b_d          = gnt_c[1] ? bus.req_b1  : bus.req_b0;
          op_d         = gnt_c[1] ? bus.req_op1 : bus.req_op0;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d    = alu_res_c;
        err_d       = alu_err_c;
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready[owner_q]) begin
          rsp_valid_d = 2'b00;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_err    = err_q;
  assign bus.busy       = busy_q;

`ifdef ALU_RR_SCHEDULER_STATS_EN
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // clear first, then count, so clear plus acceptance in one cycle lands on 1
  always_comb begin
    cnt0_d = bus.stats_clr ? '0 : cnt0_q;
    cnt1_d = bus.stats_clr ? '0 : cnt1_q;
    if (accept_c && !gnt_c[1] && (cnt0_d != '1)) cnt0_d = cnt0_d + CNT_W'(1);
    if (accept_c &&  gnt_c[1] && (cnt1_d != '1)) cnt1_d = cnt1_d + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign bus.grant_cnt0 = cnt0_q;
  assign bus.grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler: directed cases plus random traffic vs. a behavioural model.
module tb_alu_rr_scheduler;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;

  alu_rr_scheduler_if bus ();

  alu_rr_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int last_g = 1;
  int cnt[2] = '{0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU in plain integer arithmetic; returns {err, result}
  function automatic logic [16:0] ref_alu(input logic [3:0] op, input int unsigned a, input int unsigned b);
    int unsigned r;
    case (op)
      4'd1:    r = (a + b) % 65536;
      4'd2:    r = (a + 65536 - b) % 65536;
      4'd3:    r = a & b;
      4'd4:    r = a | b;
      default: return {1'b1, 16'h0000};
    endcase
    return {1'b0, 16'(r)};
  endfunction

  function automatic logic [1:0] onehot(input int g);
    return (g == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_result",    32'(bus.rsp_result), 32'd0);
    chk("rst_err",       32'(bus.rsp_err),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_g = 1;
    cnt = '{0, 0};
  endtask

  // One full transaction from IDLE; leaves the DUT in IDLE with req_valid low
  task automatic do_op(input logic [1:0] mask,
                       input logic [15:0] a0, input logic [15:0] b0, input logic [3:0] op0,
                       input logic [15:0] a1, input logic [15:0] b1, input logic [3:0] op1,
                       input int stall, input logic clr, output int g);
    logic [1:0]  oh;
    logic [16:0] exp;
    bus.req_a0 = a0; bus.req_b0 = b0; bus.req_op0 = op0;
    bus.req_a1 = a1; bus.req_b1 = b1; bus.req_op1 = op1;
    bus.req_valid = mask;
    bus.rsp_ready = 2'b00;
`ifdef ALU_RR_SCHEDULER_STATS_EN
    bus.stats_clr = clr;
`endif
    #1;
    g  = (mask == 2'b11) ? (1 - last_g) : (mask[1] ? 1 : 0);
    oh = onehot(g);
    exp = (g == 1) ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
    chk("req_ready", 32'(bus.req_ready), 32'(oh));
    @(posedge clk); #1;
    last_g = g;
    if (clr) cnt = '{0, 0};
    cnt[g]++;
`ifdef ALU_RR_SCHEDULER_STATS_EN
    bus.stats_clr = 1'b0;
`endif
    bus.req_valid[g] = 1'b0;
    chk("exec_busy",      32'(bus.busy),      32'd1);
    chk("exec_req_ready", 32'(bus.req_ready), 32'd0);
    chk("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("rsp_valid",  32'(bus.rsp_valid),  32'(oh));
    chk("rsp_result", 32'(bus.rsp_result), 32'(exp[15:0]));
    chk("rsp_err",    32'(bus.rsp_err),    32'(exp[16]));
    for (int i = 0; i < stall; i++) begin
      bus.req_valid = 2'b11;
      bus.rsp_ready = ~oh;
      @(posedge clk); #1;
      chk("stall_rsp_valid", 32'(bus.rsp_valid),  32'(oh));
      chk("stall_result",    32'(bus.rsp_result), 32'(exp[15:0]));
      chk("stall_busy",      32'(bus.busy),       32'd1);
      chk("stall_req_ready", 32'(bus.req_ready),  32'd0);
    end
    bus.rsp_ready = 2'b11;
    @(posedge clk); #1;
    chk("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("done_busy",      32'(bus.busy),      32'd0);
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b00;
  endtask

  // Accept an op, then reset during EXEC (in_resp=0) or RESP (in_resp=1)
  task automatic abort_op(input logic in_resp);
    bus.req_a0 = 16'h1234; bus.req_b0 = 16'h1111; bus.req_op0 = ALU_OP_ADD;
    bus.req_valid = 2'b01;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    if (in_resp) begin
      @(posedge clk); #1;
      chk("pre_abort_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    end
    do_reset();
  endtask

  int g;
  logic [1:0]  m;
  logic [15:0] ra0, rb0, ra1, rb1;
  logic [3:0]  rop0, rop1;

  initial begin
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req_a0 = '0; bus.req_b0 = '0; bus.req_op0 = '0;
    bus.req_a1 = '0; bus.req_b1 = '0; bus.req_op1 = '0;
`ifdef ALU_RR_SCHEDULER_STATS_EN
    bus.stats_clr = 1'b0;
`endif
    do_reset();

    // single request and add
    do_op(2'b01, 16'h0005, 16'h0003, ALU_OP_ADD, 16'h0, 16'h0, 4'h0, 0, 1'b0, g);
    chk("first_winner", 32'(g), 32'd0);
    // wrap-around from requester 1
    do_op(2'b10, 16'h0, 16'h0, 4'h0, 16'hFFFF, 16'h0002, ALU_OP_ADD, 0, 1'b0, g);
    do_op(2'b10, 16'h0, 16'h0, 4'h0, 16'h0000, 16'h0001, ALU_OP_SUB, 0, 1'b0, g);
    // lone requester 1 wins back-to-back
    chk("lone_winner", 32'(g), 32'd1);

    // contention from reset alternates 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_op(2'b11, 16'hF0F0, 16'h0FF0, ALU_OP_AND, 16'hF0F0, 16'h0FF0, ALU_OP_OR, 0, 1'b0, g);
      chk("rr_order", 32'(g), 32'(i % 2));
    end

    // backpressure with pending requests, non-owner rsp_ready ignored
    do_op(2'b11, 16'h00AA, 16'h0011, ALU_OP_SUB, 16'h0101, 16'h0202, ALU_OP_ADD, 5, 1'b0, g);
    do_op(2'b11, 16'h00AA, 16'h0011, ALU_OP_SUB, 16'h0101, 16'h0202, ALU_OP_ADD, 0, 1'b0, g);
    chk("after_stall_other", 32'(g), 32'd1);

    // illegal op codes
    do_op(2'b01, 16'h1234, 16'h5678, 4'b0111, 16'h0, 16'h0, 4'h0, 0, 1'b0, g);
    do_op(2'b10, 16'h0, 16'h0, 4'h0, 16'h1234, 16'h5678, 4'b0000, 0, 1'b0, g);
    do_op(2'b01, 16'hFFFF, 16'hFFFF, 4'b1111, 16'h0, 16'h0, 4'h0, 1, 1'b0, g);

    // dropping a request before acceptance re-evaluates the grant
    bus.req_valid = 2'b11;
    #1;
    chk("drop_pre", 32'(bus.req_ready), 32'(onehot(1 - last_g)));
    m = (last_g == 1) ? 2'b10 : 2'b01;
    bus.req_valid = m;
    #1;
    chk("drop_post", 32'(bus.req_ready), 32'(m));
    do_op(m, 16'h0007, 16'h0009, ALU_OP_OR, 16'h0007, 16'h0009, ALU_OP_AND, 0, 1'b0, g);

    // reset in EXEC and in RESP; requester 0 wins first afterwards
    abort_op(1'b0);
    do_op(2'b11, 16'h0003, 16'h0004, ALU_OP_ADD, 16'h0, 16'h0, 4'h0, 0, 1'b0, g);
    chk("post_abort_exec_winner", 32'(g), 32'd0);
    abort_op(1'b1);
    do_op(2'b11, 16'h0003, 16'h0004, ALU_OP_SUB, 16'h0, 16'h0, 4'h0, 0, 1'b0, g);
    chk("post_abort_resp_winner", 32'(g), 32'd0);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      m    = 2'($urandom_range(1, 3));
      ra0  = 16'($urandom); rb0 = 16'($urandom);
      ra1  = 16'($urandom); rb1 = 16'($urandom);
      rop0 = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
      rop1 = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
      do_op(m, ra0, rb0, rop0, ra1, rb1, rop1, int'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0), g);
`ifdef ALU_RR_SCHEDULER_STATS_EN
      chk("grant_cnt0", 32'(bus.grant_cnt0), 32'(cnt[0]));
      chk("grant_cnt1", 32'(bus.grant_cnt1), 32'(cnt[1]));
`endif
    end

`ifdef ALU_RR_SCHEDULER_STATS_EN
    // clear coinciding with an acceptance leaves that counter at 1
    do_op(2'b10, 16'h0, 16'h0, 4'h0, 16'h0001, 16'h0001, ALU_OP_ADD, 0, 1'b1, g);
    chk("clr_cnt0", 32'(bus.grant_cnt0), 32'd0);
    chk("clr_cnt1", 32'(bus.grant_cnt1), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
